// File: rtl/cat_cmd_decoder.sv
// cat_cmd_decoder: byte command decoder between the UART RX and TX paths.
// It decodes single-byte cat mask commands and the two-byte 'P'<hex>
// brightness command, returns an ACK/NAK/status byte through a single-entry
// reply register, and generates the LED PWM from the current brightness.
module cat_cmd_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 103340,
   parameter int unsigned PWM_DIV        = 1,
   parameter logic [3:0]  DUTY_RESET     = 4'd8,
   parameter logic [7:0]  ACK_CHAR       = 8'h4B,
   parameter logic [7:0]  NAK_CHAR       = 8'h21
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] cat_status,
   output logic [3:0] duty,
   output logic       pwm_out,
   output logic       overrun
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {IDLE, WAIT_ARG} state_e;

   state_e            state_q, state_d;
   logic [7:0]        cat_q, cat_d;
   logic [3:0]        duty_q, duty_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              rep_vld;
   logic [7:0]        rep_byte;
   logic [7:0]        tx_data_q;
   logic              tx_valid_q;
   logic              overrun_q;
   logic [15:0]       presc_q;
   logic [3:0]        pwm_cnt_q;
   logic              pwm_q;

   // 'A'..'H' and 'a'..'h' both have the bit number encoded as low 3 bits minus one
   logic [2:0]        bit_idx;
   logic              is_upper, is_lower, is_digit, is_hex_up, is_hex_lo;
   logic [3:0]        hex_val;

   // Byte classification shared by both states
   always_comb begin
      bit_idx   = rx_data[2:0] - 3'd1;
      is_upper  = (rx_data >= 8'h41) && (rx_data <= 8'h48);
      is_lower  = (rx_data >= 8'h61) && (rx_data <= 8'h68);
      is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
      is_hex_up = (rx_data >= 8'h41) && (rx_data <= 8'h46);
      is_hex_lo = (rx_data >= 8'h61) && (rx_data <= 8'h66);
      hex_val   = is_digit ? rx_data[3:0] : (rx_data[3:0] + 4'd9);
   end

   // Command decode: next-state for FSM, cat mask, brightness and reply request
   always_comb begin
      state_d  = state_q;
      cat_d    = cat_q;
      duty_d   = duty_q;
      to_cnt_d = to_cnt_q;
      rep_vld  = 1'b0;
      rep_byte = ACK_CHAR;
      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               if (is_upper) begin
                  cat_d[bit_idx] = 1'b0;
                  rep_vld        = 1'b1;
               end else if (is_lower) begin
                  cat_d[bit_idx] = 1'b1;
                  rep_vld        = 1'b1;
               end else if (rx_data == 8'h60) begin
                  cat_d   = 8'hFF;
                  rep_vld = 1'b1;
               end else if (rx_data == 8'h3F) begin
                  rep_vld  = 1'b1;
                  rep_byte = cat_q;
               end else if (rx_data == 8'h50) begin
                  state_d  = WAIT_ARG;
                  to_cnt_d = '0;
               end else if ((rx_data == 8'h0A) || (rx_data == 8'h0D)) begin
                  rep_vld = 1'b0;
               end else begin
                  rep_vld  = 1'b1;
                  rep_byte = NAK_CHAR;
               end
            end
         end
         WAIT_ARG: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (rx_valid) begin
               // The argument byte always ends the command; it is never re-decoded
               state_d = IDLE;
               rep_vld = 1'b1;
               if (is_digit || is_hex_up || is_hex_lo) begin
                  duty_d = hex_val;
               end else begin
                  rep_byte = NAK_CHAR;
               end
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               state_d  = IDLE;
               rep_vld  = 1'b1;
               rep_byte = NAK_CHAR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Command state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cat_q    <= 8'hFF;
         duty_q   <= DUTY_RESET;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cat_q    <= cat_d;
         duty_q   <= duty_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   // Single-entry reply register; a reply arriving while the old one is stalled is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else if (rep_vld) begin
         if (tx_valid_q && !tx_ready) begin
            overrun_q <= 1'b1;
         end else begin
            tx_data_q  <= rep_byte;
            tx_valid_q <= 1'b1;
         end
      end else if (tx_valid_q && tx_ready) begin
         tx_valid_q <= 1'b0;
      end
   end

   // PWM: prescaler steps a 4-bit ramp, output high while ramp < duty
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q   <= 16'd0;
         pwm_cnt_q <= 4'd0;
         pwm_q     <= 1'b0;
      end else begin
         if (presc_q == 16'(PWM_DIV - 1)) begin
            presc_q   <= 16'd0;
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
         end else begin
            presc_q <= presc_q + 16'd1;
         end
         pwm_q <= (pwm_cnt_q < duty_q);
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign cat_status = cat_q;
   assign duty       = duty_q;
   assign pwm_out    = pwm_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_cat_cmd_decoder.sv
// Directed bench for cat_cmd_decoder: inputs change on the falling edge,
// outputs are checked on the falling edge after the rising edge that consumed them.
module tb_cat_cmd_decoder;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] cat_status;
   logic [3:0] duty;
   logic       pwm_out;
   logic       overrun;

   int total  = 0;
   int passed = 0;

   cat_cmd_decoder #(
      .TIMEOUT_CYCLES(20),
      .PWM_DIV       (1),
      .DUTY_RESET    (4'd8),
      .ACK_CHAR      (8'h4B),
      .NAK_CHAR      (8'h21)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .cat_status(cat_status),
      .duty      (duty),
      .pwm_out   (pwm_out),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Present one byte for one cycle; returns on the falling edge after it was consumed
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic count_pwm(input int n, output int highs);
      highs = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (pwm_out) highs++;
      end
   endtask

   int hi;

   initial begin
      reset_n  = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      #12;
      chk("rst_cat", cat_status, 8'hFF);
      chk("rst_duty", {4'd0, duty}, 8'd8);
      chk("rst_txv", {7'd0, tx_valid}, 8'd0);
      chk("rst_txd", tx_data, 8'h00);
      chk("rst_ovr", {7'd0, overrun}, 8'd0);
      chk("rst_pwm", {7'd0, pwm_out}, 8'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Cat mask commands
      send(8'h43);                                   // 'C'
      chk("C_cat", cat_status, 8'hFB);
      chk("C_txv", {7'd0, tx_valid}, 8'd1);
      chk("C_txd", tx_data, 8'h4B);
      @(negedge clk);
      chk("C_txv_clr", {7'd0, tx_valid}, 8'd0);
      send(8'h66);                                   // 'f': bit 5 already set
      chk("f_cat", cat_status, 8'hFB);
      chk("f_txd", tx_data, 8'h4B);
      send(8'h3F);                                   // '?'
      chk("q1_txd", tx_data, 8'hFB);
      send(8'h60);
      chk("bq_cat", cat_status, 8'hFF);
      send(8'h41);
      chk("A_cat", cat_status, 8'hFE);
      send(8'h42);
      chk("B_cat", cat_status, 8'hFC);
      send(8'h68);                                   // 'h': set bit 7 (already set)
      send(8'h62);                                   // 'b': set bit 1
      chk("b_cat", cat_status, 8'hFE);
      send(8'h48);                                   // 'H': clear bit 7
      chk("H_cat", cat_status, 8'h7E);
      send(8'h60);
      chk("bq2_cat", cat_status, 8'hFF);
      send(8'h3F);
      chk("q2_txd", tx_data, 8'hFF);
      send(8'h5A);                                   // 'Z' unknown
      chk("Z_txd", tx_data, 8'h21);
      chk("Z_txv", {7'd0, tx_valid}, 8'd1);
      @(negedge clk);
      send(8'h0D);                                   // CR ignored
      chk("CR_txv", {7'd0, tx_valid}, 8'd0);
      send(8'h0A);                                   // LF ignored
      chk("LF_txv", {7'd0, tx_valid}, 8'd0);
      send(8'h49);                                   // 'I' just past range
      chk("I_txd", tx_data, 8'h21);
      chk("I_cat", cat_status, 8'hFF);

      // Brightness command
      send(8'h50);
      chk("P_txv", {7'd0, tx_valid}, 8'd0);
      send(8'h33);
      chk("P3_duty", {4'd0, duty}, 8'd3);
      chk("P3_txd", tx_data, 8'h4B);
      repeat (3) @(negedge clk);
      count_pwm(16, hi);
      chk("pwm3", 8'(hi), 8'd3);
      count_pwm(16, hi);
      chk("pwm3b", 8'(hi), 8'd3);
      send(8'h50);
      send(8'h78);                                   // 'x' rejected
      chk("Px_duty", {4'd0, duty}, 8'd3);
      chk("Px_txd", tx_data, 8'h21);
      send(8'h48);                                   // back in IDLE: decoded as command
      chk("Px_idle", cat_status, 8'h7F);
      send(8'h60);
      send(8'h50);
      send(8'h46);                                   // 'F'
      chk("PF_duty", {4'd0, duty}, 8'd15);
      chk("PF_cat", cat_status, 8'hFF);
      repeat (3) @(negedge clk);
      count_pwm(16, hi);
      chk("pwm15", 8'(hi), 8'd15);
      send(8'h50);
      send(8'h61);                                   // 'a'
      chk("Pa_duty", {4'd0, duty}, 8'd10);
      chk("Pa_cat", cat_status, 8'hFF);
      send(8'h50);
      send(8'h0D);                                   // CR as argument
      chk("PCR_txd", tx_data, 8'h21);
      chk("PCR_duty", {4'd0, duty}, 8'd10);
      send(8'h50);
      send(8'h30);                                   // '0'
      chk("P0_duty", {4'd0, duty}, 8'd0);
      count_pwm(16, hi);
      chk("pwm0", 8'(hi), 8'd0);
      send(8'h50);
      send(8'h61);

      // Argument timeout
      send(8'h50);
      repeat (19) @(negedge clk);
      chk("to_early", {7'd0, tx_valid}, 8'd0);
      @(negedge clk);
      chk("to_txv", {7'd0, tx_valid}, 8'd1);
      chk("to_txd", tx_data, 8'h21);
      @(negedge clk);
      send(8'h33);                                   // now a plain NAK
      chk("to_3_txd", tx_data, 8'h21);
      chk("to_3_duty", {4'd0, duty}, 8'd10);
      // Byte on the last counter cycle wins over the timeout
      send(8'h50);
      repeat (18) @(negedge clk);
      send(8'h37);
      chk("edge_duty", {4'd0, duty}, 8'd7);
      chk("edge_txd", tx_data, 8'h4B);
      @(negedge clk);
      chk("edge_no_to", {7'd0, tx_valid}, 8'd0);

      // Handshake: back-to-back load and overrun
      tx_ready = 1'b0;
      send(8'h41);
      chk("bb_A_txd", tx_data, 8'h4B);
      rx_data  = 8'h5A;
      rx_valid = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      chk("bb_txv", {7'd0, tx_valid}, 8'd1);
      chk("bb_txd", tx_data, 8'h21);
      chk("bb_ovr", {7'd0, overrun}, 8'd0);
      send(8'h42);
      chk("ov_txd", tx_data, 8'h21);
      chk("ov_ovr", {7'd0, overrun}, 8'd1);
      chk("ov_cat", cat_status, 8'hFC);
      tx_ready = 1'b1;
      @(negedge clk);
      chk("ov_drain", {7'd0, tx_valid}, 8'd0);
      chk("ov_sticky", {7'd0, overrun}, 8'd1);

      // Reset in the middle of a command with a reply pending
      tx_ready = 1'b0;
      send(8'h3F);
      send(8'h50);
      reset_n = 1'b0;
      #1;
      chk("mr_txv", {7'd0, tx_valid}, 8'd0);
      chk("mr_txd", tx_data, 8'h00);
      chk("mr_cat", cat_status, 8'hFF);
      chk("mr_duty", {4'd0, duty}, 8'd8);
      chk("mr_ovr", {7'd0, overrun}, 8'd0);
      chk("mr_pwm", {7'd0, pwm_out}, 8'd0);
      @(negedge clk);
      reset_n  = 1'b1;
      tx_ready = 1'b1;
      send(8'h35);                                   // IDLE after reset: NAK
      chk("mr_5_duty", {4'd0, duty}, 8'd8);
      send(8'h50);
      send(8'h35);
      chk("mr_P5_duty", {4'd0, duty}, 8'd5);
      chk("mr_P5_txd", tx_data, 8'h4B);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
